adc_capture_scheduler: RTL and testbench
========================================

# adc_capture_scheduler

Shares the single ADC sample stream (12-bit samples from the SPI ADC reader) between up to NUM_REQ requesters. A round-robin arbiter grants the ADC to one requester at a time. The block enables conversions, discards settling samples, counts out a burst of samples and forwards them tagged with the requester ID. It sits between the ADC reader and the capture/storage logic that currently consumes raw samples directly.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester ID, ≥ clog2(NUM_REQ)
- CNT_W, 8, burst length counter width
- DISCARD, 1, samples dropped after each adc_en rise (0..3)

Ports:
- clk  in  1  system clock (50 MHz); one clock domain; reset is synchronous and active-high
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  level request per requester; held until done or abandoned
- burst_len  in  CNT_W  samples wanted; sampled only on the grant cycle
- adc_valid  in  1  one-cycle pulse: new conversion available on adc_sample
- adc_sample  in  12  converted sample, valid with adc_valid
- adc_en  out  1  enables the ADC reader's conversion loop
- grant  out  NUM_REQ  one-hot current owner; all-zero when idle
- out_valid  out  1  forwarded sample strobe
- out_data  out  12  forwarded sample
- out_id  out  ID_W  index of owning requester, valid with out_valid
- out_last  out  1  marks final sample of burst, with out_valid
- done  out  NUM_REQ  one-cycle pulse to the requester whose burst completed
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE: if req != 0, select the first set bit scanning from (ptr+1) mod NUM_REQ upward with wrap. Then:
  - register grant and ptr = selected index
  - load cnt = burst_len and disc = DISCARD
  - next state: SETTLE if DISCARD>0, else CAPTURE
  - if burst_len == 0, go straight to DONE; adc_en is never raised.
- SETTLE: adc_en=1. Each adc_valid decrements disc and is not forwarded. When disc reaches 0, go to CAPTURE.
- CAPTURE: adc_en=1. On each adc_valid:
  - forward the sample with out_id = ptr
  - decrement cnt
  - when cnt reaches 1, set out_last, go to DONE.
- DONE: pulse done[ptr], set adc_en=0, clear grant, then go to IDLE.
- Abandon: if req[ptr] drops in SETTLE or CAPTURE, go to IDLE next cycle.
  - no done pulse
  - an adc_valid in the same cycle is dropped
  - ptr still advances
- Requests from non-owners never preempt an active burst.
- rst, including mid-burst, forces IDLE with all outputs 0 and ptr = NUM_REQ-1, so requester 0 wins first. No partial-burst flush.
- cnt is unsigned CNT_W bits. Maximum burst is 2^CNT_W − 1.

## Timing
- Reset values: adc_en=0, grant=0, out_valid=0, out_data=0, out_id=0, out_last=0, done=0, busy=0.
- Grant latency: req seen in IDLE at cycle t. Then grant, busy and adc_en are all high at t+1.
- Forwarding latency: adc_valid at cycle t produces out_valid/out_data/out_id at t+1 (registered).
- The last sample has out_last=1. The done pulse coincides with out_last (DONE cycle). busy drops in the following cycle.
- For burst_len==0: grant at t+1 and done at t+2, with adc_en low throughout.
- At least one IDLE cycle separates consecutive bursts. adc_en is low for at least one cycle between bursts, so every burst re-discards.
- out_valid never asserts with grant == 0.

## Test plan
- Reset, then req=4'b0001, burst_len=3, DISCARD=1, adc_valid every 1000 cycles with samples 0x100..0x103:
  - 0x100 is discarded
  - 0x101, 0x102, 0x103 appear with out_id=0
  - out_last on 0x103, done[0] in the same cycle, adc_en low next cycle
- req=4'b1111 held, burst_len=2: grants in order 0,1,2,3,0 with one IDLE cycle between each, and exactly 2 out_valid per grant.
- req=4'b0100 only, burst_len=0:
  - grant=4'b0100 at t+1, done[2] at t+2
  - adc_en and out_valid stay 0 throughout
- Owner 1 drops req after 1 of 5 samples:
  - no further out_valid and no done[1]
  - next grant goes to requester 2 if requesting
- Assert rst for 1 cycle mid-CAPTURE with an adc_valid in the same cycle:
  - all outputs 0 next cycle and no sample forwarded
  - a subsequent req=4'b1010 grants requester 1
- burst_len=255, DISCARD=3, adc_valid every 20 cycles: exactly 3 samples dropped and 255 forwarded, with out_last only on the 255th.

Source files
------------

// File: rtl/adc_capture_scheduler_if.sv
`timescale 1ns/1ps
// Request, ADC-side and forwarded-sample signals of the ADC capture scheduler.
// The scheduler connects through the slave modport; requesters and the ADC reader drive the master side.
interface adc_capture_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 8
) ();
  logic [NUM_REQ-1:0] req;
  logic [CNT_W-1:0]   burst_len;
  logic               adc_valid;
  logic [11:0]        adc_sample;
  logic               adc_en;
  logic [NUM_REQ-1:0] grant;
  logic               out_valid;
  logic [11:0]        out_data;
  logic [ID_W-1:0]    out_id;
  logic               out_last;
  logic [NUM_REQ-1:0] done;
  logic               busy;

  modport master (
    output req, burst_len, adc_valid, adc_sample,
    input  adc_en, grant, out_valid, out_data, out_id, out_last, done, busy
  );

  modport slave (
    input  req, burst_len, adc_valid, adc_sample,
    output adc_en, grant, out_valid, out_data, out_id, out_last, done, busy
  );
endinterface

// File: rtl/adc_capture_scheduler.sv
`timescale 1ns/1ps
// Round-robin owner of the shared ADC stream: settles, captures a burst and forwards ID-tagged samples.
// state   | meaning
// IDLE    | no owner; arbitrate among req
// SETTLE  | adc_en high, dropping DISCARD settling samples
// CAPTURE | adc_en high, forwarding samples until the burst count is exhausted
// DONE    | adc_en low, done pulse to owner, grant released on exit
module adc_capture_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 8,
  parameter int DISCARD = 1
) (
  input logic                   clk,
  input logic                   rst,
  adc_capture_scheduler_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         disc_q, disc_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               out_valid_q, out_valid_d;
  logic [11:0]        out_data_q, out_data_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  logic               out_last_q, out_last_d;

  logic [ID_W-1:0]    sel;
  logic               found;
  logic               owner_req;
  int                 idx;

  // Scan downward so the last hit is the nearest index after ptr.
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (((bus.req >> idx) & NUM_REQ'(1)) != '0) begin
        sel   = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign owner_req = |(bus.req & grant_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    disc_d      = disc_q;
    grant_d     = grant_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = NUM_REQ'(1) << sel;
          ptr_d   = sel;
          cnt_d   = bus.burst_len;
          disc_d  = 2'(DISCARD);
          if (bus.burst_len == '0) state_d = S_DONE;
          else if (DISCARD > 0)    state_d = S_SETTLE;
          else                     state_d = S_CAPTURE;
        end
      end
      S_SETTLE: begin
        if (!owner_req) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else if (bus.adc_valid) begin
          disc_d = disc_q - 2'd1;
          if (disc_q == 2'd1) state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!owner_req) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else if (bus.adc_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.adc_sample;
          out_id_d    = ptr_q;
          // cnt is left at 1 on the final sample so DONE can tell it apart from a zero-length burst.
          if (cnt_q == CNT_W'(1)) begin
            out_last_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        // Zero-length burst spends one extra DONE cycle so done trails grant by a cycle.
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      disc_q      <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      disc_q      <= disc_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.adc_en    = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.grant     = grant_q;
  assign bus.done      = (state_q == S_DONE && cnt_q != '0) ? grant_q : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_adc_capture_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for adc_capture_scheduler: the driver predicts each burst's forwarded samples,
// monitors pop and compare whenever out_valid is seen. A second instance covers DISCARD=3 with a 255-sample burst.
module tb_adc_capture_scheduler;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int CW  = 8;
  localparam int D1  = 1;
  localparam int D3  = 3;

  typedef struct {
    logic [11:0] data;
    int          id;
    bit          last;
  } exp_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst3 = 1'b1;
  always #10 clk = ~clk;

  adc_capture_scheduler_if #(.NUM_REQ(NR), .ID_W(IDW), .CNT_W(CW)) bus  ();
  adc_capture_scheduler_if #(.NUM_REQ(NR), .ID_W(IDW), .CNT_W(CW)) bus3 ();

  adc_capture_scheduler #(.NUM_REQ(NR), .ID_W(IDW), .CNT_W(CW), .DISCARD(D1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  adc_capture_scheduler #(.NUM_REQ(NR), .ID_W(IDW), .CNT_W(CW), .DISCARD(D3)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t sb3[$];
  int   m_ptr       = NR - 1;
  int   done_exp    = 0;
  int   done_seen   = 0;
  int   fwd3        = 0;
  bit   d3_finished = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arbitration: first requester after the last owner, wrapping.
  function automatic int pick(input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (m_ptr + k) % NR;
      if (((r >> i) & NR'(1)) != '0) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [11:0] v);
    bus.adc_valid  = 1'b1;
    bus.adc_sample = v;
    tick();
    bus.adc_valid  = 1'b0;
  endtask

  task automatic idle_checks();
    check("idle_grant", bus.grant, '0);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_adc_en", bus.adc_en, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_adc_en", bus.adc_en, 1'b0);
    check("rst_grant", bus.grant, '0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_id", bus.out_id, '0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_done", bus.done, '0);
    check("rst_busy", bus.busy, 1'b0);
  endtask

  task automatic do_reset();
    bus.req       = '0;
    bus.burst_len = '0;
    bus.adc_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs();
    m_ptr = NR - 1;
  endtask

  // Called at a negedge while the DUT is idle. Returns at the negedge of the idle cycle after the burst.
  // abandon >= 0: owner drops req after that many forwarded samples. gap < 0: random spacing. base < 0: random data.
  task automatic run_burst(input logic [NR-1:0] r, input int len, input int abandon,
                           input int gap, input int base);
    int          w;
    logic [NR-1:0] oh;
    logic [11:0] v;
    bus.req       = r;
    bus.burst_len = CW'(len);
    w = pick(r);
    if (w < 0) return;
    oh = NR'(1) << w;
    tick();
    check("grant", bus.grant, oh);
    check("busy", bus.busy, 1'b1);
    check("adc_en", bus.adc_en, len != 0);
    m_ptr = w;
    if (len == 0) begin
      tick();
      check("done_zero_len", bus.done, oh);
      check("adc_en_zero_len", bus.adc_en, 1'b0);
      done_exp++;
    end else begin
      for (int k = 0; k < D1 + len; k++) begin
        if (abandon >= 0 && k == D1 + abandon) begin
          bus.req = r & ~oh;
          pulse(12'hEEE);
          idle_checks();
          return;
        end
        v = (base >= 0) ? 12'(base + k) : 12'($urandom);
        if (k >= D1) sb.push_back('{v, w, (k == D1 + len - 1)});
        pulse(v);
        if (k < D1 + len - 1) repeat ((gap >= 0) ? gap : $urandom_range(0, 3)) tick();
      end
      check("done", bus.done, oh);
      check("out_last_with_done", bus.out_last, 1'b1);
      done_exp++;
    end
    tick();
    idle_checks();
  endtask

  exp_t          e;
  logic [NR-1:0] moh;
  always @(negedge clk) begin
    if (bus.done != '0) done_seen++;
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got data 0x%0h id %0d, expected no sample", bus.out_data, bus.out_id);
      end else begin
        e   = sb.pop_front();
        moh = NR'(1) << e.id;
        check("out_data", bus.out_data, e.data);
        check("out_id", bus.out_id, e.id);
        check("out_last", bus.out_last, e.last);
        check("out_grant", bus.grant, moh);
        check("out_done", bus.done, e.last ? moh : '0);
      end
    end
  end

  exp_t e3;
  always @(negedge clk) begin
    if (bus3.out_valid) begin
      fwd3++;
      if (sb3.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL d3_unexpected_out: got data 0x%0h, expected no sample", bus3.out_data);
      end else begin
        e3 = sb3.pop_front();
        check("d3_out_data", bus3.out_data, e3.data);
        check("d3_out_last", bus3.out_last, e3.last);
        check("d3_out_id", bus3.out_id, '0);
      end
    end
  end

  // 255-sample burst with three settling samples, ADC strobe every 20 cycles.
  initial begin
    logic [11:0] v;
    bus3.req        = '0;
    bus3.burst_len  = '0;
    bus3.adc_valid  = 1'b0;
    bus3.adc_sample = '0;
    repeat (3) tick();
    rst3 = 1'b0;
    bus3.req       = 4'b0001;
    bus3.burst_len = 8'd255;
    tick();
    check("d3_grant", bus3.grant, 4'b0001);
    for (int k = 0; k < D3 + 255; k++) begin
      v = 12'($urandom);
      if (k >= D3) sb3.push_back('{v, 0, (k == D3 + 254)});
      bus3.adc_valid  = 1'b1;
      bus3.adc_sample = v;
      tick();
      bus3.adc_valid  = 1'b0;
      if (k < D3 + 254) repeat (19) tick();
    end
    check("d3_done", bus3.done, 4'b0001);
    bus3.req = '0;
    tick();
    check("d3_busy_after", bus3.busy, 1'b0);
    check("d3_fwd_count", fwd3, 255);
    check("d3_sb_empty", sb3.size(), 0);
    d3_finished = 1'b1;
  end

  initial begin
    logic [NR-1:0] r;
    int            len;
    int            ab;
    bus.req        = '0;
    bus.burst_len  = '0;
    bus.adc_valid  = 1'b0;
    bus.adc_sample = '0;
    tick();
    do_reset();

    // requester 0, 3 samples, 1000-cycle ADC spacing, first sample dropped
    run_burst(4'b0001, 3, -1, 999, 12'h100);

    // all requesting: strict rotation starting at 0
    do_reset();
    for (int i = 0; i < 5; i++) run_burst(4'b1111, 2, -1, -1, -1);

    // zero-length burst
    run_burst(4'b0100, 0, -1, -1, -1);

    // owner 1 abandons after one sample, requester 2 follows
    run_burst(4'b0110, 5, 1, -1, -1);
    run_burst(4'b0100, 3, -1, -1, -1);

    // reset mid-capture with a simultaneous strobe
    bus.req       = 4'b0001;
    bus.burst_len = 8'd4;
    m_ptr         = pick(4'b0001);
    tick();
    check("pre_rst_grant", bus.grant, 4'b0001);
    pulse(12'h3A0);
    tick();
    sb.push_back('{12'h3A1, 0, 1'b0});
    pulse(12'h3A1);
    rst = 1'b1;
    pulse(12'hABC);
    rst     = 1'b0;
    bus.req = 4'b1010;
    check_reset_outputs();
    m_ptr = NR - 1;
    run_burst(4'b1010, 3, -1, -1, -1);

    // random request mixes, lengths, spacing and abandons
    for (int i = 0; i < 40; i++) begin
      r   = NR'($urandom_range(1, 15));
      len = $urandom_range(0, 6);
      ab  = (len > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(0, len - 2) : -1;
      run_burst(r, len, ab, -1, -1);
    end
    bus.req = '0;

    for (int i = 0; i < 20000 && !d3_finished; i++) tick();
    if (!d3_finished) begin
      vectors++;
      miscompares++;
      $display("FAIL d3_timeout: got unfinished, expected finished within budget");
    end
    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    check("done_count", done_seen, done_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
